// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

   // Access size encodings carried on MEM_MemSize
   typedef enum logic [1:0] {
      MEMSZ_WORD  = 2'b00,
      MEMSZ_BYTE  = 2'b01,
      MEMSZ_BYTEU = 2'b10,
      MEMSZ_HALF  = 2'b11
   } mem_size_e;

   // Access controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mau_state_e;

   // Load data returned when the bus never answers
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

   // Byte-lane enables for an access of the given size at byte offset lo
   function automatic logic [3:0] byte_enables(input mem_size_e size,
                                               input logic [1:0] lo);
      case (size)
         MEMSZ_WORD: return 4'b1111;
         MEMSZ_HALF: return 4'b0011 << lo;
         default:    return 4'b0001 << lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready bus between the access unit and the memory.
interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  dmem_req;
   logic                  dmem_we;
   logic [3:0]            dmem_be;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [31:0]           dmem_wdata;
   logic                  dmem_ready;
   logic [31:0]           dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Load lane select and sign/zero extension; purely combinational.
module mem_load_formatter
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  mem_size_e   size,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // Shift the addressed lane down to bit 0, then extend per access size
   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (size)
         MEMSZ_WORD:  data = rdata;
         MEMSZ_BYTE:  data = {{24{shifted[7]}}, shifted[7:0]};
         MEMSZ_BYTEU: data = {24'h000000, shifted[7:0]};
         MEMSZ_HALF:  data = {{16{shifted[15]}}, shifted[15:0]};
         default:     data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ready bus handshake,
// load formatting and pipeline stall generation.
// Optional BUSY watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [1:0]  MEM_MemSize,
   input  logic [31:0] MEM_ALUOut,
   input  logic [31:0] MEM_WriteData,
   input  logic        MEM_flush,
   input  logic        MEM_hold,
   output logic        MEM_stall,
   output logic [31:0] MEM_MemReadData,
   output logic        MEM_misalign,
   mem_access_unit_if.master dmem,
   output logic        bus_error
);

   mau_state_e  state, next_state;
   mem_size_e   size;
   logic [1:0]  lo;
   logic        access;
   logic        start;
   logic        abort;
   logic        timeout_hit;
   logic [1:0]  lat_lo;
   mem_size_e   lat_size;
   logic [31:0] fmt_data;

   assign size = mem_size_e'(MEM_MemSize);
   assign lo   = MEM_ALUOut[1:0];

   // Misalignment detection and access qualification
   always_comb begin
      MEM_misalign = (MEM_MemRead | MEM_MemWrite) &
                     (((size == MEMSZ_WORD) & (lo != 2'b00)) |
                      ((size == MEMSZ_HALF) & lo[0]));
      access = (MEM_MemRead | MEM_MemWrite) & ~MEM_misalign;
      start  = (state == ST_IDLE) & access & ~MEM_flush;
   end

   mem_load_formatter u_fmt (
      .rdata   (dmem.dmem_rdata),
      .addr_lo (lat_lo),
      .size    (lat_size),
      .data    (fmt_data)
   );

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] busy_cnt;

   assign timeout_hit = (state == ST_BUSY) & ~dmem.dmem_ready &
                        (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts BUSY cycles, pulses bus_error on expiry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_cnt  <= '0;
         bus_error <= 1'b0;
      end else begin
         bus_error <= timeout_hit;
         if (start)
            busy_cnt <= '0;
         else if (state == ST_BUSY)
            busy_cnt <= busy_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_error   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Next-state and stall request
   always_comb begin
      next_state = state;
      MEM_stall  = 1'b0;
      case (state)
         ST_IDLE: begin
            MEM_stall = start;
            if (start)
               next_state = ST_BUSY;
         end
         ST_BUSY: begin
            MEM_stall = 1'b1;
            // A squashed access still has to drain its bus transaction
            if (dmem.dmem_ready)
               next_state = (abort | MEM_flush) ? ST_IDLE : ST_DONE;
            else if (timeout_hit)
               next_state = ST_DONE;
         end
         ST_DONE: begin
            next_state = (MEM_hold & ~MEM_flush) ? ST_DONE : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Bus request, latched access attributes, abort flag and load result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_be    <= '0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
         MEM_MemReadData <= '0;
         lat_lo          <= '0;
         lat_size        <= MEMSZ_WORD;
         abort           <= 1'b0;
      end else if (start) begin
         dmem.dmem_req   <= 1'b1;
         dmem.dmem_we    <= MEM_MemWrite;
         dmem.dmem_be    <= byte_enables(size, lo);
         dmem.dmem_addr  <= {MEM_ALUOut[ADDR_WIDTH-1:2], 2'b00};
         dmem.dmem_wdata <= MEM_WriteData << {lo, 3'b000};
         lat_lo          <= lo;
         lat_size        <= size;
         abort           <= 1'b0;
      end else if (state == ST_BUSY) begin
         if (MEM_flush)
            abort <= 1'b1;
         if (dmem.dmem_ready) begin
            dmem.dmem_req <= 1'b0;
            abort         <= 1'b0;
            if (!dmem.dmem_we && !abort && !MEM_flush)
               MEM_MemReadData <= fmt_data;
         end else if (timeout_hit) begin
            dmem.dmem_req   <= 1'b0;
            abort           <= 1'b0;
            MEM_MemReadData <= TIMEOUT_DATA;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic        MEM_MemRead, MEM_MemWrite;
   logic [1:0]  MEM_MemSize;
   logic [31:0] MEM_ALUOut, MEM_WriteData;
   logic        MEM_flush, MEM_hold;
   logic        MEM_stall, MEM_misalign, bus_error;
   logic [31:0] MEM_MemReadData;

   int total = 0;
   int bad   = 0;

   logic [3:0]  cap_be;
   logic [31:0] cap_addr, cap_wdata;
   logic        cap_we;
   int          stall_cyc;
   bit          stable, expired;

   mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

   mem_access_unit #(
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .MEM_MemRead     (MEM_MemRead),
      .MEM_MemWrite    (MEM_MemWrite),
      .MEM_MemSize     (MEM_MemSize),
      .MEM_ALUOut      (MEM_ALUOut),
      .MEM_WriteData   (MEM_WriteData),
      .MEM_flush       (MEM_flush),
      .MEM_hold        (MEM_hold),
      .MEM_stall       (MEM_stall),
      .MEM_MemReadData (MEM_MemReadData),
      .MEM_misalign    (MEM_misalign),
      .dmem            (bus.master),
      .bus_error       (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the access already on the inputs. Returns at
   // negedge+1 of the first non-stalled cycle. The bus answers on BUSY cycle
   // ready_after (0 = never); flush pulses on BUSY cycle flush_at (0 = never).
   task automatic run_access(input int ready_after, input int flush_at,
                             input logic [31:0] rdata);
      int busy;
      busy = 0; stall_cyc = 0; stable = 1'b1; expired = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!MEM_stall) begin
            expired = 1'b0;
            break;
         end
         stall_cyc++;
         if (bus.dmem_req) begin
            busy++;
            if (busy == 1) begin
               cap_be = bus.dmem_be; cap_addr = bus.dmem_addr;
               cap_wdata = bus.dmem_wdata; cap_we = bus.dmem_we;
            end else if (cap_be !== bus.dmem_be || cap_addr !== bus.dmem_addr ||
                         cap_wdata !== bus.dmem_wdata || cap_we !== bus.dmem_we)
               stable = 1'b0;
         end
         MEM_flush = (flush_at != 0) && (busy == flush_at);
         if (MEM_flush) begin
            MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
         end
         bus.dmem_ready = (ready_after != 0) && (busy == ready_after);
         bus.dmem_rdata = rdata;
         @(negedge clk);
         bus.dmem_ready = 1'b0;
         MEM_flush = 1'b0;
      end
      check_val("cycle_bound", {31'd0, expired}, 32'd0);
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
      MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemSize = sz;
      MEM_ALUOut = addr; MEM_WriteData = wd;
   endtask

   task automatic retire;
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_hold = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bit saw_req;
      reset = 1'b0;
      set_op(1'b0, 1'b0, MEMSZ_WORD, 32'd0, 32'd0);
      MEM_flush = 1'b0; MEM_hold = 1'b0;
      bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'd0;
      #1;
      check_val("rst_req",   {31'd0, bus.dmem_req}, 32'd0);
      check_val("rst_we",    {31'd0, bus.dmem_we}, 32'd0);
      check_val("rst_be",    {28'd0, bus.dmem_be}, 32'd0);
      check_val("rst_addr",  bus.dmem_addr, 32'd0);
      check_val("rst_wdata", bus.dmem_wdata, 32'd0);
      check_val("rst_rdata", MEM_MemReadData, 32'd0);
      check_val("rst_stall", {31'd0, MEM_stall}, 32'd0);
      check_val("rst_berr",  {31'd0, bus_error}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Word load, immediate ready
      set_op(1'b1, 1'b0, MEMSZ_WORD, 32'h100, 32'd0);
      run_access(1, 0, 32'h12345678);
      check_val("lw_stall", stall_cyc, 2);
      check_val("lw_data",  MEM_MemReadData, 32'h12345678);
      check_val("lw_be",    {28'd0, cap_be}, 32'hF);
      check_val("lw_addr",  cap_addr, 32'h100);
      check_val("lw_we",    {31'd0, cap_we}, 32'd0);
      retire();

      // Signed byte load from lane 3
      set_op(1'b1, 1'b0, MEMSZ_BYTE, 32'h103, 32'd0);
      run_access(1, 0, 32'h80FFFFFF);
      check_val("lb_be",   {28'd0, cap_be}, 32'h8);
      check_val("lb_addr", cap_addr, 32'h100);
      check_val("lb_data", MEM_MemReadData, 32'hFFFFFF80);
      retire();

      // Unsigned byte load, same access
      set_op(1'b1, 1'b0, MEMSZ_BYTEU, 32'h103, 32'd0);
      run_access(1, 0, 32'h80FFFFFF);
      check_val("lbu_data", MEM_MemReadData, 32'h00000080);
      retire();

      // Halfword store at 0x202, ready on third BUSY cycle
      set_op(1'b0, 1'b1, MEMSZ_HALF, 32'h202, 32'h0000BEEF);
      run_access(3, 0, 32'h0);
      check_val("sh_addr",   cap_addr, 32'h200);
      check_val("sh_be",     {28'd0, cap_be}, 32'hC);
      check_val("sh_wdata",  cap_wdata, 32'hBEEF0000);
      check_val("sh_we",     {31'd0, cap_we}, 32'd1);
      check_val("sh_stall",  stall_cyc, 4);
      check_val("sh_stable", {31'd0, stable}, 32'd1);
      check_val("sh_keep",   MEM_MemReadData, 32'h00000080);
      retire();

      // Signed halfword load from upper lane
      set_op(1'b1, 1'b0, MEMSZ_HALF, 32'h106, 32'd0);
      run_access(2, 0, 32'h80010000);
      check_val("lh_be",    {28'd0, cap_be}, 32'hC);
      check_val("lh_data",  MEM_MemReadData, 32'hFFFF8001);
      check_val("lh_stall", stall_cyc, 3);
      retire();

      // Read and write together behave as a store
      set_op(1'b1, 1'b1, MEMSZ_WORD, 32'h500, 32'h11223344);
      run_access(1, 0, 32'hCAFEF00D);
      check_val("rw_we",    {31'd0, cap_we}, 32'd1);
      check_val("rw_wdata", cap_wdata, 32'h11223344);
      check_val("rw_keep",  MEM_MemReadData, 32'hFFFF8001);
      retire();

      // Misaligned word load never reaches the bus
      set_op(1'b1, 1'b0, MEMSZ_WORD, 32'h101, 32'd0);
      #1;
      check_val("mis_flag",  {31'd0, MEM_misalign}, 32'd1);
      check_val("mis_stall", {31'd0, MEM_stall}, 32'd0);
      saw_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (bus.dmem_req) saw_req = 1'b1;
      end
      check_val("mis_noreq", {31'd0, saw_req}, 32'd0);
      retire();

      // DONE held by MEM_hold with the access still presented
      set_op(1'b1, 1'b0, MEMSZ_WORD, 32'h104, 32'd0);
      run_access(2, 0, 32'h0BADF00D);
      MEM_hold = 1'b1;
      @(negedge clk); #1;
      check_val("hold_stall", {31'd0, MEM_stall}, 32'd0);
      check_val("hold_req",   {31'd0, bus.dmem_req}, 32'd0);
      check_val("hold_data",  MEM_MemReadData, 32'h0BADF00D);
      retire();

      // Flush on BUSY cycle 2, ready on BUSY cycle 4
      set_op(1'b1, 1'b0, MEMSZ_WORD, 32'h300, 32'd0);
      run_access(4, 2, 32'hAAAAAAAA);
      check_val("fl_stall",  stall_cyc, 5);
      check_val("fl_stable", {31'd0, stable}, 32'd1);
      check_val("fl_req",    {31'd0, bus.dmem_req}, 32'd0);
      check_val("fl_keep",   MEM_MemReadData, 32'h0BADF00D);
      @(negedge clk); #1;
      check_val("fl_idle",   {31'd0, MEM_stall}, 32'd0);
      check_val("fl_keep2",  MEM_MemReadData, 32'h0BADF00D);
      @(negedge clk);

      // Reset asserted while BUSY
      set_op(1'b1, 1'b0, MEMSZ_HALF, 32'h402, 32'h0);
      @(negedge clk); #1;
      check_val("rb_req", {31'd0, bus.dmem_req}, 32'd1);
      @(negedge clk); #3;
      reset = 1'b0;
      MEM_MemRead = 1'b0;
      #1;
      check_val("rb_req0",   {31'd0, bus.dmem_req}, 32'd0);
      check_val("rb_be0",    {28'd0, bus.dmem_be}, 32'd0);
      check_val("rb_addr0",  bus.dmem_addr, 32'd0);
      check_val("rb_data0",  MEM_MemReadData, 32'd0);
      check_val("rb_stall0", {31'd0, MEM_stall}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'h55555555;
      @(negedge clk);
      bus.dmem_ready = 1'b0;
      #1;
      check_val("late_rdy_data",  MEM_MemReadData, 32'd0);
      check_val("late_rdy_req",   {31'd0, bus.dmem_req}, 32'd0);
      check_val("late_rdy_stall", {31'd0, MEM_stall}, 32'd0);
      @(negedge clk);

`ifdef MEM_ACCESS_TIMEOUT_EN
      // No answer: watchdog fires after 8 BUSY cycles
      set_op(1'b1, 1'b0, MEMSZ_WORD, 32'h600, 32'd0);
      run_access(0, 0, 32'h0);
      check_val("to_stall", stall_cyc, 9);
      check_val("to_berr",  {31'd0, bus_error}, 32'd1);
      check_val("to_data",  MEM_MemReadData, 32'hDEADBEEF);
      check_val("to_req",   {31'd0, bus.dmem_req}, 32'd0);
      retire();
      #1;
      check_val("to_berr_pulse", {31'd0, bus_error}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access controller. It sits between the EX/MEM register outputs and the MEM/WB register.
- Turns MEM_MemRead/MEM_MemWrite into a req/ready handshake on the data-memory bus.
- Formats load data into MEM_MemReadData.
- Raises MEM_stall until the access completes, so the MEM/WB register and the upstream stages hold.

Parameters:
ADDR_WIDTH, 32, data-memory byte-address width (dmem_addr width).
TIMEOUT_CYCLES, 255, BUSY-state watchdog limit; used only with MEM_ACCESS_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
MEM_MemRead  input  1  load in MEM stage
MEM_MemWrite  input  1  store in MEM stage
MEM_MemSize  input  2  00 word, 01 byte signed, 10 byte unsigned, 11 halfword signed
MEM_ALUOut  input  32  effective byte address
MEM_WriteData  input  32  store data, right-aligned
MEM_flush  input  1  squash current MEM instruction
MEM_hold  input  1  downstream hold; keeps the DONE result alive
MEM_stall  output  1  combinational stall request to pipeline
MEM_MemReadData  output  32  formatted load data
MEM_misalign  output  1  misaligned-access flag, combinational
dmem_req  output  1  bus request, registered
dmem_we  output  1  bus write enable
dmem_be  output  4  byte enables
dmem_addr  output  ADDR_WIDTH  word-aligned address
dmem_wdata  output  32  lane-shifted store data
dmem_ready  input  1  bus completion, single-cycle pulse
dmem_rdata  input  32  bus read data, valid with dmem_ready
bus_error  output  1  one-cycle timeout pulse

Behaviour:
- Reset (reset=0, async): state=IDLE; dmem_req, dmem_we, bus_error = 0; dmem_be, dmem_addr, dmem_wdata, MEM_MemReadData = 0; internal abort flag cleared.
- access = (MEM_MemRead | MEM_MemWrite) & ~MEM_misalign.
- Misalignment: word with addr[1:0]!=0, or halfword with addr[0]!=0, sets MEM_misalign=1. No bus request is made and no stall is raised.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access=1, MEM_flush=0:
  - MEM_stall=1.
  - Latch address {addr[ADDR_WIDTH-1:2],2'b00}, we, be and lane-shifted wdata.
  - Set dmem_req=1 and go to BUSY.
- BUSY:
  - MEM_stall=1.
  - dmem_req, addr, we, be and wdata stay stable until dmem_ready.
  - On dmem_ready: dmem_req<=0, capture the formatted dmem_rdata (loads only; stores leave the value unchanged), go to DONE.
- DONE:
  - MEM_stall=0; MEM_MemReadData is valid this cycle.
  - MEM_hold=1: stay in DONE.
  - Otherwise: go to IDLE. The next instruction is examined in IDLE the following cycle.
- Minimum stall: 2 cycles (ready seen on the first BUSY cycle). Total = 2 + ready wait.
- Byte enables:
  - word: 1111
  - halfword: 0011 << addr[1:0]
  - byte: 0001 << addr[1:0]
- Load formatting:
  - Select the byte or halfword lane by addr[1:0].
  - Sign- or zero-extend to 32 bits per MEM_MemSize.
- MEM_MemRead and MEM_MemWrite both high: treated as a write.
- MEM_flush:
  - In IDLE: no request is started.
  - In BUSY: the bus transaction cannot be retracted. Set the abort flag, wait for dmem_ready, then go directly to IDLE without updating MEM_MemReadData. MEM_stall stays 1 until ready.
  - In DONE: go to IDLE.
- Reset mid-BUSY: the request drops immediately. A late dmem_ready is ignored in IDLE.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN
- Defined:
  - An 8+-bit counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no dmem_ready: dmem_req<=0, MEM_MemReadData<=32'hDEADBEEF, bus_error pulses 1 cycle, go to DONE.
- Not defined: BUSY waits indefinitely; bus_error is tied 0; no counter logic exists.

Decomposition:
- Shared package holds:
  - MemSize encodings (MEMSZ_WORD/BYTE/BYTEU/HALF)
  - FSM state encodings
  - 32'hDEADBEEF timeout constant
- One natural sub-module: mem_load_formatter (combinational lane select and sign/zero extension). Reused by WB-side forwarding if needed.

Test Plan:
- Word load, addr 0x100, dmem_ready on first BUSY cycle, rdata 0x12345678 -> MEM_stall high exactly 2 cycles; MEM_MemReadData=0x12345678 in DONE; dmem_be=1111.
- Signed byte load at 0x103, rdata 0x80FFFFFF -> be=1000; MEM_MemReadData=0xFFFFFF80. Same access as unsigned byte -> 0x00000080.
- Halfword store at 0x202, wdata 0x0000BEEF, ready after 3 cycles -> dmem_addr=0x200, be=1100, dmem_wdata[31:16]=0xBEEF, we=1; stall 4 cycles.
- Word load at 0x101 -> MEM_misalign=1, dmem_req never asserted, MEM_stall=0.
- MEM_flush in the 2nd BUSY cycle, ready in the 4th -> req held until ready, then IDLE; MEM_MemReadData keeps its prior value. Reset asserted mid-BUSY -> all outputs 0 asynchronously.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ready -> after 8 BUSY cycles: bus_error pulses, MEM_MemReadData=0xDEADBEEF, MEM_stall falls.
